// File: rtl/stoch_frame_decoder.sv
//==============================================================================
// Module      : stoch_frame_decoder
// Description : Counts ones in a stochastic bitstream over a 2^n-cycle window
//               and reports the result as an n-bit binary value.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module stoch_frame_decoder #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         Y,
    output logic [n-1:0] a,
    output logic         valid,
    output logic         busy,
    output logic         sat
);

    localparam int unsigned    c_W        = 1 << n;
    localparam logic [n:0]     c_W_CNT    = (n+1)'(c_W);
    localparam logic [n-1:0]   c_LAST_WIN = n'(c_W - 1);
    localparam logic [n-1:0]   c_A_MAX    = n'(c_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [n:0]     ones_q, ones_d;
    logic [n-1:0]   win_q, win_d;
    logic [n-1:0]   a_q, a_d;
    logic           sat_q, sat_d;
    logic [n:0]     ones_final;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ones_q  <= '0;
            win_q   <= '0;
            a_q     <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ones_q  <= ones_d;
            win_q   <= win_d;
            a_q     <= a_d;
            sat_q   <= sat_d;
        end
    end

    // Count including the sample taken on the current edge.
    assign ones_final = ones_q + {{n{1'b0}}, Y};

    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        win_d   = win_q;
        a_d     = a_q;
        sat_d   = sat_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COUNT;
                    ones_d  = '0;
                    win_d   = '0;
                end
            end

            COUNT: begin
                ones_d = ones_final;
                win_d  = win_q + 1'b1;
                if (win_q == c_LAST_WIN) begin
                    state_d = DONE;
                    // A full window of ones cannot be represented in n bits.
                    sat_d   = (ones_final == c_W_CNT);
                    a_d     = (ones_final == c_W_CNT) ? c_A_MAX : ones_final[n-1:0];
                end
            end

            DONE: begin
                if (start) begin
                    state_d = COUNT;
                    ones_d  = '0;
                    win_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign a     = a_q;
    assign sat   = sat_q;
    assign valid = (state_q == DONE);
    assign busy  = (state_q == COUNT);

endmodule

`default_nettype wire

// File: tb/tb_stoch_frame_decoder.sv
//==============================================================================
// Module      : tb_stoch_frame_decoder
// Description : Scoreboard bench for stoch_frame_decoder with random windows.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_stoch_frame_decoder;

    localparam int N = 4;
    localparam int W = 1 << N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         Y = 1'b0;
    logic [N-1:0] a;
    logic         valid;
    logic         busy;
    logic         sat;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int a;
        int sat;
        int cyc;
    } exp_t;

    exp_t exp_q[$];

    stoch_frame_decoder #(.n(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Y     (Y),
        .a     (a),
        .valid (valid),
        .busy  (busy),
        .sat   (sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation on every valid pulse; otherwise a/sat must hold.
    int   hold_a   = 0;
    int   hold_sat = 0;
    int   busy_run = 0;
    exp_t e;

    always @(negedge clk) begin
        if (rst) begin
            hold_a   = 0;
            hold_sat = 0;
            busy_run = 0;
            chk("rst_a", int'(a), 0);
            chk("rst_sat", int'(sat), 0);
            chk("rst_valid", int'(valid), 0);
            chk("rst_busy", int'(busy), 0);
        end else begin
            if (valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("a", int'(a), e.a);
                    chk("sat", int'(sat), e.sat);
                    chk("valid_cycle", cyc, e.cyc);
                    hold_a   = e.a;
                    hold_sat = e.sat;
                end
                chk("busy_in_done", int'(busy), 0);
            end else begin
                chk("hold_a", int'(a), hold_a);
                chk("hold_sat", int'(sat), hold_sat);
            end
            if (busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                chk("busy_len", busy_run, W);
                busy_run = 0;
            end
        end
    end

    // One window: accept edge with Y=y0, then W sample edges. abort_at>0 pulses rst
    // just after that sample edge. gap = idle cycles with start low afterwards.
    task automatic run_window(input logic [W-1:0] bits, input logic y0,
                              input logic [W-1:0] st, input int abort_at,
                              input int gap);
        int   c0;
        int   cnt;
        exp_t x;
        @(negedge clk);
        start = 1'b1;
        Y     = y0;
        c0    = cyc;
        @(posedge clk);
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            Y     = bits[i-1];
            start = st[i-1];
            @(posedge clk);
            if (i == abort_at) begin
                #2 rst = 1'b1;
                #1;
                chk("abort_a", int'(a), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_valid", int'(valid), 0);
                @(posedge clk);
                #2 rst = 1'b0;
                start = 1'b0;
                return;
            end
        end
        cnt   = $countones(bits);
        x.a   = (cnt >= W) ? W - 1 : cnt;
        x.sat = (cnt == W) ? 1 : 0;
        x.cyc = c0 + W + 1;
        exp_q.push_back(x);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            start = 1'b0;
            Y     = 1'($urandom_range(1));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] bits;
        logic [W-1:0] st;
        int           p;
        int           ab;
        int           t;

        // Reset held with start high: must stay idle.
        start = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);

        run_window({W{1'b1}}, 1'b0, '0, 0, 2);
        run_window({W{1'b0}}, 1'b1, '0, 0, 3);
        bits = 16'h1249;
        run_window(bits, 1'b1, '0, 0, 1);
        run_window({W{1'b1}}, 1'b1, '0, 8, 0);
        run_window({W{1'b1}}, 1'b0, '0, 0, 2);

        // Continuous start, alternating Y: back-to-back windows every W+1 cycles.
        bits = 16'h5555;
        for (int k = 0; k < 4; k++)
            run_window(bits, 1'b1, {W{1'b1}}, 0, (k == 3) ? 2 : 0);

        for (int k = 0; k < 30; k++) begin
            p = $urandom_range(W);
            for (int b = 0; b < W; b++)
                bits[b] = ($urandom_range(W - 1) < p);
            st = W'($urandom);
            ab = ($urandom_range(7) == 0) ? $urandom_range(W - 1, 1) : 0;
            run_window(bits, 1'($urandom_range(1)), st, ab, $urandom_range(3));
        end

        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
